pwm_bank: RTL and testbench

Multi-channel, memory-mapped PWM peripheral that generalises the CPU's single `port_pwm1` output into `CHANNELS` independent outputs. Each channel has its own period, duty, polarity and alignment mode, with glitch-free shadow reloads at period boundaries. It sits on the MMU's memory-side bus (address, data in/out, write enable, data ready) beside the RAM, and raises per-channel period-wrap interrupts.

---
 rtl/pwm_bank.sv | 277 +++++++++++++++++++++++++++
 tb/tb_pwm_bank.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel memory-mapped PWM peripheral.
//
// Each channel has its own period, duty, polarity and (optionally) centre
// alignment. PERIOD/DUTY writes land in shadow registers and are copied to the
// active registers at a period wrap, so the waveform never glitches.
// A shared prescaler produces the count tick for all channels.
//
// Optional feature macro: PWM_CENTER_ALIGNED_EN
//   defined   -> CTRL bit2 (CENTER) and up/down counting are built.
//   undefined -> CTRL bit2 reads 0, all channels run edge-aligned.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   address       byte address, address[7:2] decoded
//   data_in       write data
//   write_enable  one-cycle write strobe
//   read_enable   one-cycle read strobe
//   data_out      registered read data (valid the cycle after read_enable)
//   data_ready    access acknowledge (cycle after any strobe)
//   pwm_out       registered PWM outputs, one per channel
//   period_irq    one-cycle wrap pulse, one per channel
//
// Register map: 0x00 PRESCALE, 0x04 STATUS (W1C), channel n at 0x10+0x10*n:
//   +0 CTRL {CENTER,POL,EN}, +4 PERIOD, +8 DUTY, +C COUNT (read-only).
module pwm_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         address,
    input  logic [31:0]         data_in,
    input  logic                write_enable,
    input  logic                read_enable,
    output logic [31:0]         data_out,
    output logic                data_ready,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [CHANNELS-1:0] period_irq
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Address decode: word index split into 16-byte block and register slot.
    logic [5:0] word_idx;
    logic [3:0] blk;
    logic [1:0] reg_sel;
    logic [3:0] ch_idx;
    logic       ch_hit;

    assign word_idx = address[7:2];
    assign blk      = word_idx[5:2];
    assign reg_sel  = word_idx[1:0];
    assign ch_idx   = blk - 4'd1;
    assign ch_hit   = (blk != 4'd0) && (int'(blk) <= CHANNELS);

    logic unused_ok;
    assign unused_ok = ^{address[31:8], address[1:0], data_in};

    // Shared prescaler
    logic [WIDTH-1:0] prescale_q;
    logic [WIDTH-1:0] div_q;
    logic             tick;

    assign tick = (div_q >= prescale_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescale_q <= '0;
            div_q      <= '0;
        end else if (write_enable && word_idx == 6'd0) begin
            prescale_q <= data_in[WIDTH-1:0];
            div_q      <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + ONE;
        end
    end

    // Per-channel views for the read mux and status logic
    logic [2:0]       ctrl_w    [CHANNELS];
    logic [WIDTH-1:0] per_sh_w  [CHANNELS];
    logic [WIDTH-1:0] duty_sh_w [CHANNELS];
    logic [WIDTH-1:0] cnt_w     [CHANNELS];
    logic [CHANNELS-1:0] pend_vec;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic             en_q, pol_q, en_d, pol_d;
        logic [WIDTH-1:0] per_sh_q, duty_sh_q, per_sh_d, duty_sh_d;
        logic [WIDTH-1:0] per_act_q, duty_act_q, per_act_d, duty_act_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic             wrap, pend_q, irq_q, pwm_q;
        logic             wr_sel;
`ifdef PWM_CENTER_ALIGNED_EN
        logic             center_q, center_d;
        logic             dir_q, dir_d;     // 1 = counting down
`endif

        assign wr_sel = write_enable && ch_hit && (ch_idx == 4'(gi));

        always_comb begin
            en_d      = en_q;
            pol_d     = pol_q;
            per_sh_d  = per_sh_q;
            duty_sh_d = duty_sh_q;
`ifdef PWM_CENTER_ALIGNED_EN
            center_d  = center_q;
`endif
            if (wr_sel) begin
                case (reg_sel)
                    2'd0: begin
                        en_d  = data_in[0];
                        pol_d = data_in[1];
`ifdef PWM_CENTER_ALIGNED_EN
                        center_d = data_in[2];
`endif
                    end
                    2'd1:    per_sh_d  = data_in[WIDTH-1:0];
                    2'd2:    duty_sh_d = data_in[WIDTH-1:0];
                    default: ;
                endcase
            end
        end

        // Counter; the *_sh_d values are used for reloads so a shadow write
        // landing on the wrap edge is taken at that wrap.
        always_comb begin
            cnt_d      = cnt_q;
            per_act_d  = per_act_q;
            duty_act_d = duty_act_q;
            wrap       = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
            dir_d      = dir_q;
`endif
            if (!en_q) begin
                // Disabled (also covers the enable edge): park and track shadows.
                cnt_d      = '0;
                per_act_d  = per_sh_d;
                duty_act_d = duty_sh_d;
`ifdef PWM_CENTER_ALIGNED_EN
                dir_d      = 1'b0;
`endif
            end else if (tick && per_act_q != '0) begin
`ifdef PWM_CENTER_ALIGNED_EN
                if (center_q) begin
                    // A stale down direction at 0 (mode switch) restarts upward.
                    if ((!dir_q || cnt_q == '0) && cnt_q < per_act_q) begin
                        cnt_d = cnt_q + ONE;
                        dir_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - ONE;
                        dir_d = 1'b1;
                        if (cnt_d == '0) begin
                            wrap  = 1'b1;
                            dir_d = 1'b0;
                        end
                    end
                end else
`endif
                begin
                    if (cnt_q >= per_act_q) begin
                        cnt_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                if (wrap) begin
                    per_act_d  = per_sh_d;
                    duty_act_d = duty_sh_d;
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                en_q       <= 1'b0;
                pol_q      <= 1'b0;
                per_sh_q   <= '0;
                duty_sh_q  <= '0;
                per_act_q  <= '0;
                duty_act_q <= '0;
                cnt_q      <= '0;
                pend_q     <= 1'b0;
                irq_q      <= 1'b0;
                pwm_q      <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
                center_q   <= 1'b0;
                dir_q      <= 1'b0;
`endif
            end else begin
                en_q       <= en_d;
                pol_q      <= pol_d;
                per_sh_q   <= per_sh_d;
                duty_sh_q  <= duty_sh_d;
                per_act_q  <= per_act_d;
                duty_act_q <= duty_act_d;
                cnt_q      <= cnt_d;
                // Output follows COUNT by one clk; the irq is delayed one more
                // so it lines up with the output showing the wrapped COUNT.
                pwm_q      <= (en_q && (cnt_q < duty_act_q)) ^ pol_q;
                pend_q     <= wrap;
                irq_q      <= pend_q;
`ifdef PWM_CENTER_ALIGNED_EN
                center_q   <= center_d;
                dir_q      <= dir_d;
`endif
            end
        end

`ifdef PWM_CENTER_ALIGNED_EN
        assign ctrl_w[gi] = {center_q, pol_q, en_q};
`else
        assign ctrl_w[gi] = {1'b0, pol_q, en_q};
`endif
        assign per_sh_w[gi]  = per_sh_q;
        assign duty_sh_w[gi] = duty_sh_q;
        assign cnt_w[gi]     = cnt_q;
        assign pend_vec[gi]  = pend_q;
        assign pwm_out[gi]   = pwm_q;
        assign period_irq[gi] = irq_q;
    end

    // Sticky status; a set arriving with a W1C on the same bit wins.
    logic [CHANNELS-1:0] status_q, status_clr;

    assign status_clr = (write_enable && word_idx == 6'd1) ? data_in[CHANNELS-1:0] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q <= '0;
        end else begin
            status_q <= (status_q & ~status_clr) | pend_vec;
        end
    end

    // Read mux uses pre-write register values.
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        if (word_idx == 6'd0) begin
            rdata[WIDTH-1:0] = prescale_q;
        end else if (word_idx == 6'd1) begin
            rdata[CHANNELS-1:0] = status_q;
        end else if (ch_hit) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (ch_idx == 4'(i)) begin
                    case (reg_sel)
                        2'd0:    rdata[2:0]       = ctrl_w[i];
                        2'd1:    rdata[WIDTH-1:0] = per_sh_w[i];
                        2'd2:    rdata[WIDTH-1:0] = duty_sh_w[i];
                        default: rdata[WIDTH-1:0] = cnt_w[i];
                    endcase
                end
            end
        end
    end

    logic [31:0] data_out_q;
    logic        data_ready_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_q   <= '0;
            data_ready_q <= 1'b0;
        end else begin
            data_out_q   <= read_enable ? rdata : 32'd0;
            data_ready_q <= read_enable | write_enable;
        end
    end

    assign data_out   = data_out_q;
    assign data_ready = data_ready_q;

endmodule

// File: tb/tb_pwm_bank.sv
module tb_pwm_bank;
    localparam int CH = 4;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   address, data_in, data_out;
    logic          write_enable, read_enable, data_ready;
    logic [CH-1:0] pwm_out, period_irq;

    pwm_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .address(address), .data_in(data_in),
        .write_enable(write_enable), .read_enable(read_enable),
        .data_out(data_out), .data_ready(data_ready),
        .pwm_out(pwm_out), .period_irq(period_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_read;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t sb_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: every data_ready pulse consumes one scoreboard entry.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (data_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_ready: got data_ready=1 expected 0");
                end else begin
                    it = sb_q.pop_front();
                    if (it.is_read) check(it.name, data_out, it.exp);
                end
            end
        end
    end

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        item_t it;
        @(negedge clk);
        address = {24'h0, a}; data_in = d; write_enable = 1'b1;
        it.is_read = 1'b0; it.exp = '0; it.name = "wr";
        sb_q.push_back(it);
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, input logic [31:0] exp, input string name);
        item_t it;
        @(negedge clk);
        address = {24'h0, a}; read_enable = 1'b1;
        it.is_read = 1'b1; it.exp = exp; it.name = name;
        sb_q.push_back(it);
        @(negedge clk);
        read_enable = 1'b0;
    endtask

    // Same-cycle read and write: read returns the old value.
    task automatic bus_rw(input logic [7:0] a, input logic [31:0] d, input logic [31:0] exp, input string name);
        item_t it;
        @(negedge clk);
        address = {24'h0, a}; data_in = d; read_enable = 1'b1; write_enable = 1'b1;
        it.is_read = 1'b1; it.exp = exp; it.name = name;
        sb_q.push_back(it);
        @(negedge clk);
        read_enable = 1'b0; write_enable = 1'b0;
    endtask

    function automatic logic [31:0] bits(input string s);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++) r[i] = (s[i] == 8'h31);
        return r;
    endfunction

    // Waits (bounded) for pwm_out[ch] to change to 'want'; returns irq at that sample.
    task automatic wait_edge(input int ch, input logic want, input string name, output logic irq_s);
        logic prev, cur, found;
        found = 1'b0; irq_s = 1'b0;
        prev = pwm_out[ch];
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            cur = pwm_out[ch];
            if (cur == want && prev != want) begin
                found = 1'b1;
                irq_s = period_irq[ch];
            end
            prev = cur;
        end
        check(name, 32'(found), 32'd1);
    endtask

    task automatic capture(input int ch, input int n, output logic [31:0] pw, output logic [31:0] iq);
        pw = '0; iq = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pw[i] = pwm_out[ch];
            iq[i] = period_irq[ch];
        end
    endtask

    initial begin
        logic [31:0] pw, iq;
        logic        irq_s;
        logic [7:0]  a;
        int          k;

        rst = 1'b0; address = '0; data_in = '0; write_enable = 1'b0; read_enable = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_irq", 32'(period_irq), 32'd0);
        check("reset_ready", 32'(data_ready), 32'd0);
        rst = 1'b1;

        // Every mapped offset reads 0 after reset
        bus_read(8'h00, 32'd0, "rst_prescale");
        bus_read(8'h04, 32'd0, "rst_status");
        for (int c = 0; c < CH; c++) begin
            for (int r = 0; r < 4; r++) begin
                a = 8'(8'h10 + 8'h10 * c + 4 * r);
                bus_read(a, 32'd0, $sformatf("rst_ch%0d_off%0h", c, 4 * r));
            end
        end
        check("idle_pwm", 32'(pwm_out), 32'd0);

        // Read+write together; unmapped and read-only accesses
        bus_rw(8'h00, 32'd3, 32'd0, "rw_old_prescale");
        bus_read(8'h00, 32'd3, "rw_new_prescale");
        bus_write(8'h00, 32'd0);
        bus_read(8'h50, 32'd0, "unmapped_ch4_ctrl");
        bus_write(8'h54, 32'hFFFF);
        bus_read(8'h54, 32'd0, "unmapped_ch4_period");
        bus_write(8'h1C, 32'd5);
        bus_read(8'h1C, 32'd0, "count_ro");

        // Ch0 edge mode: PERIOD=9, DUTY=3 -> 3 high / 7 low, irq every 10
        bus_write(8'h14, 32'd9);
        bus_write(8'h18, 32'd3);
        bus_write(8'h10, 32'd1);
        repeat (15) @(negedge clk);
        wait_edge(0, 1'b1, "ch0_rise", irq_s);
        check("ch0_irq_at_wrap", 32'(irq_s), 32'd1);
        capture(0, 19, pw, iq);
        check("ch0_wave", pw, bits("1100000001110000000"));
        check("ch0_irq_wave", iq, bits("0000000001000000000"));
        bus_read(8'h04, 32'h1, "ch0_status");
        bus_read(8'h10, 32'h1, "ch0_ctrl");

        // Mid-period DUTY change takes effect at the next wrap
        wait_edge(0, 1'b1, "ch0_rise2", irq_s);
        fork
            capture(0, 19, pw, iq);
            bus_write(8'h18, 32'd7);
        join
        check("ch0_duty_reload", pw, bits("1100000001111111000"));

        bus_write(8'h10, 32'd0);
        repeat (3) @(negedge clk);
        bus_write(8'h04, 32'h1);
        bus_read(8'h04, 32'h0, "status_w1c");
        bus_read(8'h1C, 32'h0, "ch0_count_disabled");
        check("ch0_idle", 32'(pwm_out[0]), 32'd0);

        // Ch1: PRESCALE=1, PERIOD=4, DUTY=2, POL=1, CENTER requested
        bus_write(8'h00, 32'd1);
        bus_write(8'h24, 32'd4);
        bus_write(8'h28, 32'd2);
        bus_write(8'h20, 32'd7);
`ifdef PWM_CENTER_ALIGNED_EN
        bus_read(8'h20, 32'd7, "ch1_ctrl");
`else
        bus_read(8'h20, 32'd3, "ch1_ctrl");
`endif
        repeat (25) @(negedge clk);
        wait_edge(1, 1'b0, "ch1_fall", irq_s);
        capture(1, 19, pw, iq);
`ifdef PWM_CENTER_ALIGNED_EN
        check("ch1_wave_center", pw, bits("0000011111111110000"));
`else
        check("ch1_wave_edge", pw, bits("0001111110000111111"));
`endif

        // Ch2 boundaries: DUTY=0 -> POL; DUTY=PERIOD+1 -> !POL
        bus_write(8'h34, 32'd5);
        bus_write(8'h38, 32'd0);
        bus_write(8'h30, 32'd3);
        repeat (5) @(negedge clk);
        capture(2, 12, pw, iq);
        check("ch2_duty0", pw, bits("111111111111"));
        bus_write(8'h38, 32'd6);
        repeat (30) @(negedge clk);
        capture(2, 12, pw, iq);
        check("ch2_duty_over", pw, bits("000000000000"));

        // Ch3: PERIOD=0, DUTY=1 -> constant high, never wraps
        bus_write(8'h44, 32'd0);
        bus_write(8'h48, 32'd1);
        bus_write(8'h40, 32'd1);
        repeat (5) @(negedge clk);
        capture(3, 20, pw, iq);
        check("ch3_period0_wave", pw, bits("11111111111111111111"));
        check("ch3_period0_irq", iq, 32'd0);
        bus_read(8'h4C, 32'd0, "ch3_count");
        bus_read(8'h04, 32'h6, "status_ch1_ch2");

        // Asynchronous reset mid-period with all channels enabled
        bus_write(8'h10, 32'd1);
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_pwm", 32'(pwm_out), 32'd0);
        check("async_rst_irq", 32'(period_irq), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < CH; c++) begin
            bus_read(8'(8'h10 + 8'h10 * c), 32'd0, $sformatf("post_rst_ctrl%0d", c));
            bus_read(8'(8'h1C + 8'h10 * c), 32'd0, $sformatf("post_rst_count%0d", c));
        end
        check("post_rst_pwm", 32'(pwm_out), 32'd0);

        k = 0;
        while (sb_q.size() != 0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
